// File: rtl/adc_pll_ctrl.sv
// Sequencer for the 4-phase ADC sampling PLL: reset/lock qualification, timeout retries,
// lock-loss recovery and the glitch-safe capture-phase switch handshake.
`timescale 1ns/1ps
module adc_pll_ctrl #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SWITCH_CYCLES       = 8,
    parameter int unsigned PHASE_DEFAULT       = 0
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    input  logic       phase_req,
    input  logic [1:0] phase_in,
    output logic       phase_ack,
    output logic [1:0] phase_sel,
    output logic       adc_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] relock_cnt
);

    localparam int unsigned RW = (RST_CYCLES > 1)          ? $clog2(RST_CYCLES)          : 1;
    localparam int unsigned SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned XW = (SWITCH_CYCLES > 1)       ? $clog2(SWITCH_CYCLES)       : 1;

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [XW-1:0] SW_LAST     = XW'(SWITCH_CYCLES - 1);
    localparam logic [XW-1:0] SW_HALF     = XW'(SWITCH_CYCLES / 2 - 1);
    localparam logic [1:0]    RETRY_LAST  = 2'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        SWITCH,
        FAULT
    } state_t;

    state_t        state, state_next;
    logic          sync1, locked_s;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] to_cnt;
    logic [XW-1:0] sw_cnt;
    logic [1:0]    pending;
    logic          qualifying, timeout;

    assign qualifying = (state == WAIT_LOCK) || (state == STABLE);
    assign timeout    = qualifying && (to_cnt == TO_LAST);

    always_ff @(posedge refclk) begin
        if (rst) state <= RESET_PLL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pll_rst    = 1'b0;
        adc_rst    = 1'b1;
        ready      = 1'b0;
        fault      = 1'b0;
        phase_ack  = 1'b0;
        case (state)
            RESET_PLL: begin
                pll_rst = 1'b1;
                if (rst_cnt == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (timeout)
                    state_next = (retry_cnt == RETRY_LAST) ? FAULT : RESET_PLL;
                else if (locked_s)
                    state_next = (LOCK_STABLE_CYCLES == 1) ? RUN : STABLE;
            end
            STABLE: begin
                if (timeout)
                    state_next = (retry_cnt == RETRY_LAST) ? FAULT : RESET_PLL;
                else if (!locked_s)
                    state_next = WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST)
                    state_next = RUN;
            end
            RUN: begin
                adc_rst = 1'b0;
                ready   = 1'b1;
                if (!locked_s)      state_next = RESET_PLL;
                else if (phase_req) state_next = SWITCH;
            end
            SWITCH: begin
                // The ack is suppressed if lock is lost on the final cycle, since that cycle aborts.
                if (!locked_s) begin
                    state_next = RESET_PLL;
                end else if (sw_cnt == SW_LAST) begin
                    phase_ack  = 1'b1;
                    state_next = RUN;
                end
            end
            FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
            default: state_next = RESET_PLL;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1      <= 1'b0;
            locked_s   <= 1'b0;
            rst_cnt    <= '0;
            stable_cnt <= '0;
            to_cnt     <= '0;
            sw_cnt     <= '0;
            pending    <= 2'(PHASE_DEFAULT);
            phase_sel  <= 2'(PHASE_DEFAULT);
            retry_cnt  <= '0;
            relock_cnt <= '0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;

            if (state == RESET_PLL && state_next == RESET_PLL) rst_cnt <= rst_cnt + 1'b1;
            else                                               rst_cnt <= '0;

            // Timeout spans WAIT_LOCK and STABLE together; it only restarts via RESET_PLL.
            if (qualifying && !timeout) to_cnt <= to_cnt + 1'b1;
            else                        to_cnt <= '0;

            if (state == WAIT_LOCK && locked_s)
                stable_cnt <= SW'(1);
            else if (state == STABLE && locked_s && stable_cnt != STABLE_LAST)
                stable_cnt <= stable_cnt + 1'b1;
            else
                stable_cnt <= '0;

            if (state == SWITCH) sw_cnt <= sw_cnt + 1'b1;
            else                 sw_cnt <= '0;

            if (state == RUN && locked_s && phase_req) pending <= phase_in;

            if (state == SWITCH && locked_s && sw_cnt == SW_HALF) phase_sel <= pending;

            if (timeout)
                retry_cnt <= retry_cnt + 1'b1;
            else if (qualifying && state_next == RUN)
                retry_cnt <= '0;

            if ((state == RUN || state == SWITCH) && !locked_s && relock_cnt != 8'hFF)
                relock_cnt <= relock_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_adc_pll_ctrl.sv
// Scoreboard bench for adc_pll_ctrl with short timing parameters.
`timescale 1ns/1ps
module tb_adc_pll_ctrl;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       phase_req;
    logic [1:0] phase_in;
    logic       phase_ack;
    logic [1:0] phase_sel;
    logic       adc_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] relock_cnt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    adc_pll_ctrl #(
        .RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2),
        .SWITCH_CYCLES(4),
        .PHASE_DEFAULT(0)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .phase_req(phase_req),
        .phase_in(phase_in),
        .phase_ack(phase_ack),
        .phase_sel(phase_sel),
        .adc_rst(adc_rst),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt),
        .relock_cnt(relock_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Leaves the bench one cycle after rst falls (cycle 0 of the new run).
    task automatic do_reset(input logic lock);
        rst = 1'b1; pll_locked = lock; phase_req = 1'b0; phase_in = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; phase_req = 1'b0; phase_in = 2'd0;
        repeat (3) tick();
        total++;
        if ({pll_rst, adc_rst, ready, fault, phase_ack} !== 5'b11000) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 11000", {pll_rst, adc_rst, ready, fault, phase_ack});
        end
        total++;
        if ({phase_sel, retry_cnt, relock_cnt} !== 12'd0) begin
            bad++; $display("FAIL reset_counts: got sel=%0d retry=%0d relock=%0d expected 0/0/0", phase_sel, retry_cnt, relock_cnt);
        end
        rst = 1'b0;
        total++;
        if ({pll_rst, adc_rst, ready, fault} !== 4'b1100) begin
            bad++; $display("FAIL reset_after_release: got %b expected 1100", {pll_rst, adc_rst, ready, fault});
        end
    endtask

    task automatic test_power_up();
        int rst_fall, rdy_rise, e;
        rst_fall = -1; rdy_rise = -1;
        do_reset(1'b0);
        exp_q.push_back(4);
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin pll_locked = 1'b1; exp_q.push_back(c + 10); end
            if (rst_fall < 0 && pll_rst === 1'b0) rst_fall = c;
            if (rdy_rise < 0 && ready === 1'b1) rdy_rise = c;
            tick();
        end
        e = exp_q.pop_front(); total++;
        if (rst_fall !== e) begin bad++; $display("FAIL pwr_pll_rst_len: got %0d expected %0d", rst_fall, e); end
        e = exp_q.pop_front(); total++;
        if (rdy_rise !== e) begin bad++; $display("FAIL pwr_ready_cycle: got %0d expected %0d", rdy_rise, e); end
        total++;
        if ({adc_rst, phase_sel, retry_cnt} !== 5'd0) begin
            bad++; $display("FAIL pwr_run_state: got adc_rst=%0d sel=%0d retry=%0d expected 0/0/0", adc_rst, phase_sel, retry_cnt);
        end
    endtask

    task automatic test_lock_glitch();
        int rdy_rise, e;
        rdy_rise = -1;
        do_reset(1'b0);
        for (int c = 0; c < 40; c++) begin
            if (c == 5)  pll_locked = 1'b1;
            if (c == 10) pll_locked = 1'b0;
            if (c == 11) begin pll_locked = 1'b1; exp_q.push_back(c + 10); end
            if (rdy_rise < 0 && ready === 1'b1) rdy_rise = c;
            tick();
        end
        e = exp_q.pop_front(); total++;
        if (rdy_rise !== e) begin bad++; $display("FAIL glitch_ready_cycle: got %0d expected %0d", rdy_rise, e); end
        total++;
        if ({retry_cnt, relock_cnt} !== 10'd0) begin
            bad++; $display("FAIL glitch_counts: got retry=%0d relock=%0d expected 0/0", retry_cnt, relock_cnt);
        end
    endtask

    task automatic test_timeout_fault();
        int trans[$];
        int fault_c, retry_mid, acks, e, got;
        logic prev;
        fault_c = -1; retry_mid = -1; acks = 0;
        do_reset(1'b0);
        exp_q.push_back(4); exp_q.push_back(36); exp_q.push_back(40); exp_q.push_back(72);
        prev = pll_rst;
        for (int c = 0; c < 100; c++) begin
            if (pll_rst !== prev) trans.push_back(c);
            prev = pll_rst;
            if (fault_c < 0 && fault === 1'b1) fault_c = c;
            if (c == 38) retry_mid = int'(retry_cnt);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            got = (i < trans.size()) ? trans[i] : -1;
            total++;
            if (got !== e) begin bad++; $display("FAIL timeout_pll_rst_edge%0d: got %0d expected %0d", i, got, e); end
        end
        total++;
        if (trans.size() !== 4) begin bad++; $display("FAIL timeout_edge_count: got %0d expected 4", trans.size()); end
        total++;
        if (fault_c !== 72) begin bad++; $display("FAIL fault_cycle: got %0d expected 72", fault_c); end
        total++;
        if (retry_mid !== 1) begin bad++; $display("FAIL retry_after_first_timeout: got %0d expected 1", retry_mid); end
        total++;
        if ({fault, pll_rst, adc_rst, ready, retry_cnt} !== 6'b111010) begin
            bad++; $display("FAIL fault_outputs: got %b expected 111010", {fault, pll_rst, adc_rst, ready, retry_cnt});
        end
        pll_locked = 1'b1; phase_req = 1'b1; phase_in = 2'd3;
        for (int c = 0; c < 30; c++) begin
            if (phase_ack === 1'b1) acks++;
            tick();
        end
        phase_req = 1'b0;
        total++;
        if (acks !== 0 || fault !== 1'b1 || phase_sel !== 2'd0) begin
            bad++; $display("FAIL fault_ignores_req: got acks=%0d fault=%0d sel=%0d expected 0/1/0", acks, fault, phase_sel);
        end
        do_reset(1'b0);
        total++;
        if ({fault, retry_cnt} !== 3'b000) begin
            bad++; $display("FAIL fault_cleared_by_rst: got fault=%0d retry=%0d expected 0/0", fault, retry_cnt);
        end
    endtask

    task automatic reach_run();
        do_reset(1'b1);
        for (int k = 0; k < 60 && ready !== 1'b1; k++) tick();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL reach_run: got ready=%0d expected 1", ready); end
        tick();
    endtask

    task automatic test_phase_change();
        int low, sel_c, ack_c, acks, rdy_after, e;
        low = 0; sel_c = -1; ack_c = -1; acks = 0; rdy_after = -1;
        reach_run();
        phase_in = 2'd2; phase_req = 1'b1;
        exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(1);
        for (int c = 1; c <= 12; c++) begin
            if (ready !== 1'b1 && adc_rst === 1'b1) low++;
            if (sel_c < 0 && phase_sel === 2'd2) sel_c = c;
            if (ack_c >= 0 && c == ack_c + 1) rdy_after = int'(ready);
            if (phase_ack === 1'b1) begin acks++; ack_c = c; end
            tick();
            if (ack_c == c) phase_req = 1'b0;
        end
        e = exp_q.pop_front(); total++;
        if (low !== e) begin bad++; $display("FAIL switch_hold_len: got %0d expected %0d", low, e); end
        e = exp_q.pop_front(); total++;
        if (sel_c !== e) begin bad++; $display("FAIL switch_sel_cycle: got %0d expected %0d", sel_c, e); end
        e = exp_q.pop_front(); total++;
        if (ack_c !== e) begin bad++; $display("FAIL switch_ack_cycle: got %0d expected %0d", ack_c, e); end
        e = exp_q.pop_front(); total++;
        if (acks !== e) begin bad++; $display("FAIL switch_ack_count: got %0d expected %0d", acks, e); end
        total++;
        if (rdy_after !== 1) begin bad++; $display("FAIL switch_ready_after_ack: got %0d expected 1", rdy_after); end
    endtask

    task automatic test_same_phase();
        int low, sel_bad, ack_c, e;
        low = 0; sel_bad = 0; ack_c = -1;
        phase_in = 2'd2; phase_req = 1'b1;
        exp_q.push_back(5); exp_q.push_back(4);
        for (int c = 1; c <= 10; c++) begin
            if (ready !== 1'b1) low++;
            if (phase_sel !== 2'd2) sel_bad++;
            if (phase_ack === 1'b1) ack_c = c;
            tick();
            if (ack_c == c) phase_req = 1'b0;
        end
        e = exp_q.pop_front(); total++;
        if (ack_c !== e) begin bad++; $display("FAIL same_phase_ack_cycle: got %0d expected %0d", ack_c, e); end
        e = exp_q.pop_front(); total++;
        if (low !== e) begin bad++; $display("FAIL same_phase_hold_len: got %0d expected %0d", low, e); end
        total++;
        if (sel_bad !== 0) begin bad++; $display("FAIL same_phase_sel_stable: got %0d changed cycles expected 0", sel_bad); end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        int sel_mid, e, got;
        sel_mid = -1;
        phase_in = 2'd1; phase_req = 1'b1;
        exp_q.push_back(5); exp_q.push_back(10);
        for (int c = 1; c <= 16; c++) begin
            if (c == 6) phase_in = 2'd3;
            if (c == 8) sel_mid = int'(phase_sel);
            if (phase_ack === 1'b1) acks.push_back(c);
            tick();
            if (acks.size() == 2 && acks[1] == c) phase_req = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            got = (i < acks.size()) ? acks[i] : -1;
            total++;
            if (got !== e) begin bad++; $display("FAIL b2b_ack%0d_cycle: got %0d expected %0d", i, got, e); end
        end
        total++;
        if (acks.size() !== 2) begin bad++; $display("FAIL b2b_ack_count: got %0d expected 2", acks.size()); end
        total++;
        if (sel_mid !== 1 || phase_sel !== 2'd3) begin
            bad++; $display("FAIL b2b_sel: got mid=%0d final=%0d expected 1/3", sel_mid, phase_sel);
        end
    endtask

    task automatic test_switch_abort();
        int acks[$];
        int prst, rdy_c, sel10, relock5, e, got;
        prst = 0; rdy_c = -1; sel10 = -1; relock5 = -1;
        phase_in = 2'd1; phase_req = 1'b1; pll_locked = 1'b0;
        exp_q.push_back(20); exp_q.push_back(4); exp_q.push_back(16);
        for (int c = 1; c <= 40; c++) begin
            if (c == 4) pll_locked = 1'b1;
            if (pll_rst === 1'b1) prst++;
            if (c == 5) relock5 = int'(relock_cnt);
            if (c == 10) sel10 = int'(phase_sel);
            if (rdy_c < 0 && c > 1 && ready === 1'b1) rdy_c = c;
            if (phase_ack === 1'b1) acks.push_back(c);
            tick();
            if (acks.size() == 1 && acks[0] == c) phase_req = 1'b0;
        end
        e = exp_q.pop_front(); got = (acks.size() > 0) ? acks[0] : -1; total++;
        if (got !== e || acks.size() !== 1) begin
            bad++; $display("FAIL abort_ack: got first=%0d count=%0d expected %0d/1", got, acks.size(), e);
        end
        e = exp_q.pop_front(); total++;
        if (prst !== e) begin bad++; $display("FAIL abort_pll_rst_len: got %0d expected %0d", prst, e); end
        e = exp_q.pop_front(); total++;
        if (rdy_c !== e) begin bad++; $display("FAIL abort_rerun_cycle: got %0d expected %0d", rdy_c, e); end
        total++;
        if (relock5 !== 1 || relock_cnt !== 8'd1) begin
            bad++; $display("FAIL abort_relock: got c5=%0d end=%0d expected 1/1", relock5, relock_cnt);
        end
        total++;
        if (sel10 !== 3 || phase_sel !== 2'd1) begin
            bad++; $display("FAIL abort_sel: got held=%0d final=%0d expected 3/1", sel10, phase_sel);
        end
    endtask

    task automatic test_relock_saturation();
        int model, e;
        model = 0;
        reach_run();
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            model = (model < 255) ? model + 1 : 255;
            exp_q.push_back(model);
            for (int k = 0; k < 10 && ready !== 1'b0; k++) tick();
            for (int k = 0; k < 40 && ready !== 1'b1; k++) tick();
            e = exp_q.pop_front(); total++;
            if (ready !== 1'b1 || relock_cnt !== 8'(e)) begin
                bad++; $display("FAIL relock_event%0d: got ready=%0d relock=%0d expected 1/%0d", i, ready, relock_cnt, e);
            end
        end
        total++;
        if (relock_cnt !== 8'd255) begin bad++; $display("FAIL relock_saturated: got %0d expected 255", relock_cnt); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_timeout_fault();
        test_phase_change();
        test_same_phase();
        test_back_to_back();
        test_switch_abort();
        test_relock_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_pll_ctrl.md
Name: adc_pll_ctrl

Overview:
- Sequences the 4-phase 40 MHz ADC sampling PLL: drives the PLL reset, qualifies lock, recovers from lock loss and retries on lock timeout.
- Owns the ADC capture-phase selection (which of outclk_0..3 samples the ADC).
- Runs a glitch-safe phase-change handshake that holds ADC capture in reset while the phase switches.
- Sits between the PLL instance and the ADC capture/Ethernet packetiser logic, clocked by the free-running 50 MHz reference.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (min 1).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-locked cycles required before ready.
- LOCK_TIMEOUT_CYCLES, 65536: max cycles in WAIT_LOCK+STABLE per attempt.
- MAX_RETRIES, 3: timeouts tolerated before FAULT (min 1).
- SWITCH_CYCLES, 8: adc_rst hold length around a phase change (min 2).
- PHASE_DEFAULT, 0: capture phase after rst (0..3).

Ports:
- refclk  in  1  50 MHz free-running clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked, asynchronous; 2-flop synchronised internally.
- pll_rst  out  1  PLL reset.
- phase_req  in  1  phase-change request; held high until phase_ack.
- phase_in  in  2  requested phase index, sampled on the phase_req && grant cycle.
- phase_ack  out  1  one-cycle pulse: new phase applied.
- phase_sel  out  2  current capture-phase index to the clock mux.
- adc_rst  out  1  hold ADC capture/packetiser in reset.
- ready  out  1  PLL qualified and capture running.
- fault  out  1  sticky: retries exhausted.
- retry_cnt  out  2  timeouts in the current lock campaign.
- relock_cnt  out  8  lock-loss events since rst; saturates at 255.

Behaviour:
- Reset values, applied while rst=1 and in the cycle after it falls:
  - State RESET_PLL; all counters 0.
  - pll_rst=1, adc_rst=1, ready=0, fault=0, phase_ack=0.
  - phase_sel=PHASE_DEFAULT, retry_cnt=0, relock_cnt=0.
  - Synchroniser flops cleared to 0.
- locked_s is pll_locked delayed by 2 refclk cycles. All decisions use locked_s.
- States:
  - RESET_PLL:
    - pll_rst=1, adc_rst=1, ready=0.
    - After exactly RST_CYCLES cycles, go to WAIT_LOCK. Timeout and stable counters are cleared on entry.
  - WAIT_LOCK:
    - pll_rst=0. The timeout counter increments each cycle.
    - locked_s=1: go to STABLE with stable count=1.
  - STABLE:
    - Timeout counter keeps running. locked_s=1 increments the stable count.
    - locked_s=0: return to WAIT_LOCK. Stable count is cleared; no retry, no relock count.
    - Stable count reaches LOCK_STABLE_CYCLES: go to RUN. From the next cycle ready=1 and adc_rst=0, and retry_cnt clears to 0.
  - Timeout (WAIT_LOCK or STABLE):
    - Timeout counter reaches LOCK_TIMEOUT_CYCLES: retry_cnt+1.
    - New retry_cnt == MAX_RETRIES: go to FAULT. Otherwise go to RESET_PLL.
  - RUN:
    - ready=1, adc_rst=0, pll_rst=0.
    - locked_s=0: next cycle ready=0 and adc_rst=1, relock_cnt+1 (saturating), go to RESET_PLL.
    - phase_req=1 with locked_s=1: capture phase_in into pending, go to SWITCH.
  - SWITCH:
    - ready=0, adc_rst=1. Waits SWITCH_CYCLES cycles.
    - phase_sel updates to pending after SWITCH_CYCLES/2 cycles, mid-hold, so the mux change happens with capture reset.
    - On the final cycle, pulse phase_ack for 1 cycle, then return to RUN with ready=1 and adc_rst=0.
    - Request for the currently selected phase: full SWITCH still executes; phase_sel is unchanged.
    - locked_s=0 during SWITCH: abort. No ack; phase_sel keeps whatever value it already has. relock_cnt+1, go to RESET_PLL.
  - FAULT:
    - pll_rst=1, adc_rst=1, ready=0, fault=1. phase_req is ignored (no ack).
    - Exit only via rst.
- phase_req outside RUN stays pending (requester keeps it high) and is granted on the first RUN cycle. phase_in is sampled at grant, not at request.
- Latency, request to ack while in RUN: 1 (grant) + SWITCH_CYCLES.
- Requester must hold phase_req until it sees ack and drop it the cycle after. A req still high in the cycle after ack is a new request.
- Counters are sized with clog2 of their parameter. No wrap except relock_cnt, which saturates.

Test Plan:
- Bench parameters: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, SWITCH_CYCLES=4.
- Power-up: rst for 3 cycles, release, pll_locked=1 from cycle 6.
  - pll_rst high exactly 4 cycles after rst falls.
  - ready rises 2 (sync) + 8 cycles after lock.
  - phase_sel=0, retry_cnt=0.
- Lock glitch in STABLE: pll_locked low 1 cycle at stable count 5.
  - Back to WAIT_LOCK; ready delayed by a full 8 further cycles.
  - retry_cnt=0, relock_cnt=0.
- Timeout/fault: pll_locked held 0.
  - pll_rst re-pulses once after 32 cycles (retry_cnt=1).
  - Second timeout gives fault=1, pll_rst=1, retry_cnt=2.
  - phase_req=1 gets no ack. Only rst clears fault.
- Phase change in RUN: phase_req=1, phase_in=2.
  - ready=0 and adc_rst=1 for 4 cycles; phase_sel becomes 2 after 2 cycles.
  - phase_ack pulses once, 5 cycles after req; ready=1 next cycle.
- Lock loss mid-SWITCH: pll_locked drops during SWITCH.
  - No phase_ack; relock_cnt=1; pll_rst pulses 4 cycles.
  - Held phase_req is granted on re-entry to RUN.
- Relock saturation: 256 lock-loss events from RUN → relock_cnt stays 255.
